// File: rtl/tx_gearbox_66b_if.sv
// Block-in / word-out bus of the 66b transmit gearbox.
// master = block source and word sink side, slave = gearbox side.
interface tx_gearbox_66b_if #(
  parameter int unsigned OUT_W = 16
);
  logic [63:0]      data;
  logic [1:0]       syn;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] op;
  logic             op_valid;
  logic             hdr_err;

  modport master (
    output data, syn, in_valid,
    input  in_ready, op, op_valid, hdr_err
  );

  modport slave (
    input  data, syn, in_valid,
    output in_ready, op, op_valid, hdr_err
  );
endinterface

// File: rtl/tx_gearbox_66b.sv
// 66b -> OUT_W transmit gearbox: bit buffer with fill count, LSB-first output words.
// Optional payload scrambler (x^58+x^39+1) enabled by defining TX_GEARBOX_SCRAMBLE_EN.
module tx_gearbox_66b #(
  parameter int unsigned OUT_W = 16
) (
  input logic             clk,
  input logic             rst,
  tx_gearbox_66b_if.slave bus
);
  localparam int unsigned PLD_W = 64;
  localparam int unsigned BLK_W = PLD_W + 2;
  localparam int unsigned BUF_W = BLK_W + OUT_W;
  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] op_q, op_d;
  logic             op_valid_q, op_valid_d;
  logic             hdr_err_q, hdr_err_d;

  logic             accept_c;
  logic             drain_c;
  logic [PLD_W-1:0] payload_c;
  logic [BUF_W-1:0] shifted_c;
  logic [CNT_W-1:0] base_c;

  // Ready depends on registered fill only, so the source never sees a comb path back.
  assign bus.in_ready = (cnt_q <= CNT_W'(2 * OUT_W));
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign drain_c      = (cnt_q >= CNT_W'(OUT_W));

`ifdef TX_GEARBOX_SCRAMBLE_EN
  localparam int unsigned SCR_W = 58;

  logic [SCR_W-1:0] scr_q, scr_d;

  // Serial self-synchronous scrambler unrolled over the 64 payload bits, data[0] first.
  always_comb begin
    logic s;
    scr_d     = scr_q;
    payload_c = '0;
    s         = 1'b0;
    for (int i = 0; i < int'(PLD_W); i++) begin
      s            = bus.data[i] ^ scr_d[38] ^ scr_d[57];
      payload_c[i] = s;
      scr_d        = {scr_d[SCR_W-2:0], s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_q <= '1;
    end else if (accept_c) begin
      scr_q <= scr_d;
    end
  end
`else
  assign payload_c = bus.data;
`endif

  // Drain from the pre-edge buffer, then append the new block behind what remains.
  always_comb begin
    shifted_c  = drain_c ? (bits_q >> OUT_W) : bits_q;
    base_c     = drain_c ? (cnt_q - CNT_W'(OUT_W)) : cnt_q;
    bits_d     = shifted_c;
    cnt_d      = base_c;
    op_d       = op_q;
    op_valid_d = drain_c;
    hdr_err_d  = 1'b0;
    if (drain_c) begin
      op_d = bits_q[OUT_W-1:0];
    end
    if (accept_c) begin
      bits_d    = shifted_c | (BUF_W'({payload_c, bus.syn}) << base_c);
      cnt_d     = base_c + CNT_W'(BLK_W);
      hdr_err_d = (bus.syn[1] == bus.syn[0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q     <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      bits_q     <= bits_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  assign bus.op       = op_q;
  assign bus.op_valid = op_valid_q;
  assign bus.hdr_err  = hdr_err_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_W'(BUF_W));

endmodule

// File: tb/tb_tx_gearbox_66b.sv
// Randomised bench for tx_gearbox_66b against a bit-queue reference model.
module tb_tx_gearbox_66b;
`ifdef TX_GEARBOX_SCRAMBLE_EN
  localparam int unsigned OUT_W = 32;
`else
  localparam int unsigned OUT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tx_gearbox_66b_if #(.OUT_W(OUT_W)) bus ();
  tx_gearbox_66b #(.OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: serial bit stream still owed to the line, and scrambler output history.
  bit mq[$];
  bit hist[$];
  logic [OUT_W-1:0] exp_op;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    exp_op = '0;
  endtask

  // s_i = d_i ^ s_(i-39) ^ s_(i-58); hist[57] is the newest scrambled bit.
  function automatic logic [63:0] scramble_ref(input logic [63:0] d);
    logic [63:0] r;
`ifdef TX_GEARBOX_SCRAMBLE_EN
    bit s;
    for (int i = 0; i < 64; i++) begin
      s = d[i] ^ hist[19] ^ hist[0];
      void'(hist.pop_front());
      hist.push_back(s);
      r[i] = s;
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // Called at a negedge: drive inputs, run one clock, check outputs at the next negedge.
  task automatic cycle(input bit v, input logic [63:0] d, input logic [1:0] s, output bit acc);
    bit exp_rdy, exp_ov, exp_he;
    logic [63:0] pd;
    bus.in_valid = v;
    bus.data     = d;
    bus.syn      = s;
    exp_rdy = (mq.size() <= int'(2 * OUT_W));
    #1;
    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    exp_ov = (mq.size() >= int'(OUT_W));
    if (exp_ov) begin
      for (int i = 0; i < int'(OUT_W); i++) exp_op[i] = mq.pop_front();
    end
    exp_he = acc && (s[1] == s[0]);
    if (acc) begin
      pd = scramble_ref(d);
      mq.push_back(s[0]);
      mq.push_back(s[1]);
      for (int i = 0; i < 64; i++) mq.push_back(pd[i]);
    end
    @(negedge clk);
    check_eq("op_valid", 64'(bus.op_valid), 64'(exp_ov));
    check_eq("op", 64'(bus.op), 64'(exp_op));
    check_eq("hdr_err", 64'(bus.hdr_err), 64'(exp_he));
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_op_valid", 64'(bus.op_valid), 64'd0);
    check_eq("rst_op", 64'(bus.op), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_hdr_err", 64'(bus.hdr_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit a;
    logic [63:0] d;
    logic [1:0]  s;
    logic [65:0] blk;
    int acc_n, words, run, maxrun;
    bit seen_nr, pend;
    logic [OUT_W-1:0] w[$];

    bus.data = '0;
    bus.syn = 2'b01;
    bus.in_valid = 1'b0;
    #2;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'd0, 2'b01, a);

    // Single block, 2 residual bits left behind
    cycle(1'b1, 64'h0123_4567_89AB_CDEF, 2'b01, a);
    cycle(1'b0, 64'd0, 2'b01, a);
`ifndef TX_GEARBOX_SCRAMBLE_EN
    check_eq("t2_word0", 64'(bus.op), 64'h37BD);
`endif
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 2'b01, a);

    // Back-to-back blocks with in_valid held high
    do_reset();
    acc_n = 0; words = 0; run = 0; maxrun = 0; seen_nr = 1'b0;
    d = {$urandom, $urandom};
    s = ($urandom % 2) ? 2'b01 : 2'b10;
    for (int c = 0; c < 100 && acc_n < 8; c++) begin
      cycle(1'b1, d, s, a);
      if (bus.op_valid) begin words++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      if (!bus.in_ready) seen_nr = 1'b1;
      if (a) begin
        acc_n++;
        d = {$urandom, $urandom};
        s = ($urandom % 2) ? 2'b01 : 2'b10;
      end
    end
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, d, s, a);
      if (bus.op_valid) begin words++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check_eq("b2b_accepted", 64'(acc_n), 64'd8);
    check_eq("b2b_words", 64'(words), 64'((8 * 66) / OUT_W));
    check_eq("b2b_consecutive", 64'(maxrun), 64'((8 * 66) / OUT_W));
    check_eq("b2b_ready_drop", 64'(seen_nr), 64'd1);

    // Illegal header
    do_reset();
    cycle(1'b1, {$urandom, $urandom}, 2'b11, a);
    check_eq("hdr_err_pulse", 64'(bus.hdr_err), 64'd1);
    cycle(1'b0, 64'd0, 2'b01, a);
    check_eq("hdr_bits", 64'(bus.op[1:0]), 64'h3);
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 2'b01, a);

    // Reset in the middle of a block
    do_reset();
    cycle(1'b1, {$urandom, $urandom}, 2'b10, a);
    cycle(1'b0, 64'd0, 2'b01, a);
    cycle(1'b0, 64'd0, 2'b01, a);
    do_reset();
    d = {$urandom, $urandom};
    blk = {d, 2'b01};
    cycle(1'b1, d, 2'b01, a);
    cycle(1'b0, 64'd0, 2'b01, a);
`ifndef TX_GEARBOX_SCRAMBLE_EN
    check_eq("post_rst_word0", 64'(bus.op), 64'(blk[OUT_W-1:0]));
`endif
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 2'b01, a);

`ifdef TX_GEARBOX_SCRAMBLE_EN
    // All-zero payloads expose the keystream from the all-ones seed
    do_reset();
    acc_n = 0;
    w.delete();
    for (int c = 0; c < 40; c++) begin
      cycle(acc_n < 3, 64'd0, 2'b10, a);
      if (a) acc_n++;
      if (bus.op_valid) w.push_back(bus.op);
    end
    check_eq("scr_words", 64'(w.size()), 64'd6);
    if (w.size() >= 6) begin
      check_eq("scr_word0", 64'(w[0]), 64'h0000_0002);
      check_eq("scr_word1", 64'(w[1]), 64'h0FFF_FE00);
      check_eq("scr_hdr1", 64'(w[2][3:2]), 64'h2);
      check_eq("scr_hdr2", 64'(w[4][5:4]), 64'h2);
    end
`endif

    // Random traffic, source holds its block until accepted
    do_reset();
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        d = {$urandom, $urandom};
        s = 2'($urandom % 4);
        pend = ($urandom % 4) != 0;
      end
      cycle(pend, d, s, a);
      if (a) pend = 1'b0;
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 64'd0, 2'b01, a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
